// File: rtl/nbit_decoder_seq.sv
// rtl/nbit_decoder_seq.sv - registered N-to-2^N one-hot decoder with enable, valid capture and auto-scan
// Scan mode (SCAN state, dwell counter, o_wrap) is built only when DEC_SCAN_EN is defined.
module nbit_decoder_seq #(
   parameter int N        = 2,
   parameter int SCAN_DIV = 4
) (
   input  logic                i_clk,
   input  logic                i_rst,
   input  logic                i_en,
   input  logic                i_mode,
   input  logic                i_valid,
   input  logic [N-1:0]        i_I,
   output logic [(1<<N)-1:0]   o_Y,
   output logic                o_valid,
   output logic [N-1:0]        o_idx,
   output logic                o_wrap
);
   localparam int W = 1 << N;
   localparam logic [W-1:0] ONE = W'(1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DECODE = 2'd1,
      SCAN   = 2'd2
   } state_t;

   state_t         state, state_n;
   logic [W-1:0]   y_n;
   logic           valid_n;
   logic [N-1:0]   idx_n;
   logic           wrap_n;

`ifdef DEC_SCAN_EN
   localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
   logic [CW-1:0]  cnt, cnt_n;
`else
   logic           unused_cfg;
   assign unused_cfg = i_mode ^ (SCAN_DIV < 1);
`endif

   always_comb begin
      state_n = state;
      y_n     = o_Y;
      valid_n = 1'b0;
      idx_n   = o_idx;
      wrap_n  = 1'b0;
`ifdef DEC_SCAN_EN
      cnt_n   = '0;
`endif
      if (!i_en) begin
         state_n = IDLE;
         y_n     = '0;
      end
`ifdef DEC_SCAN_EN
      else if (i_mode) begin
         state_n = SCAN;
         if (state != SCAN) begin
            idx_n = '0;
            y_n   = ONE;
         end else if (cnt == CNT_LAST) begin
            // terminal dwell count: advance, flag the roll from the top line back to 0
            idx_n  = o_idx + N'(1);
            y_n    = ONE << idx_n;
            wrap_n = &o_idx;
         end else begin
            cnt_n = cnt + CW'(1);
         end
      end
`endif
      else begin
         state_n = DECODE;
         if (state != DECODE)
            y_n = '0;
         if (i_valid) begin
            y_n     = ONE << i_I;
            idx_n   = i_I;
            valid_n = 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state   <= IDLE;
         o_Y     <= '0;
         o_valid <= 1'b0;
         o_idx   <= '0;
         o_wrap  <= 1'b0;
`ifdef DEC_SCAN_EN
         cnt     <= '0;
`endif
      end else begin
         state   <= state_n;
         o_Y     <= y_n;
         o_valid <= valid_n;
         o_idx   <= idx_n;
         o_wrap  <= wrap_n;
`ifdef DEC_SCAN_EN
         cnt     <= cnt_n;
`endif
      end
   end

endmodule
